cpu_step_ctrl: RTL and testbench

Run/step/breakpoint controller for the single-cycle CPU shown on the board and LCD. It converts the raw run switch and step button into one-cycle clock-enable pulses (cpu_en) that advance the datapath. In RUN it paces execution with a prescaler, and it halts on a PC breakpoint. Sits between the SWI inputs and the CPU's register and PC write enables. It also exports state and a retired-instruction count for the LED/LCD.

---
 rtl/cpu_step_ctrl_if.sv | 27 ++
 rtl/cpu_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_ctrl_if.sv
// Bundles the switch, breakpoint and CPU-side signals of the run/step controller.
// master is the controller; slave is the board/CPU side that drives the inputs.
interface cpu_step_ctrl_if #(
    parameter int unsigned NBITS_TOP = 8,
    parameter int unsigned CNT_BITS  = 16
);
    logic                 run_sw;
    logic                 step_btn;
    logic                 bkpt_en;
    logic [NBITS_TOP-1:0] bkpt_addr;
    logic [NBITS_TOP-1:0] pc;
    logic                 clr_cnt;
    logic                 cpu_en;
    logic [1:0]           state;
    logic                 halted;
    logic [CNT_BITS-1:0]  instr_count;

    modport master (
        input  run_sw, step_btn, bkpt_en, bkpt_addr, pc, clr_cnt,
        output cpu_en, state, halted, instr_count
    );

    modport slave (
        output run_sw, step_btn, bkpt_en, bkpt_addr, pc, clr_cnt,
        input  cpu_en, state, halted, instr_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint controller: turns the run switch and step button into one-cycle
// CPU enable pulses, paced by a prescaler in RUN and stopped by a PC breakpoint.
module cpu_step_ctrl #(
    parameter int unsigned NBITS_TOP  = 8,
    parameter int unsigned RUN_DIV    = 4,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_BITS   = 16
) (
    input logic              clk_2,
    input logic              rst_n,
    cpu_step_ctrl_if.master  bus
);

    localparam int unsigned PresW = $clog2(RUN_DIV);
    localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
    localparam logic [PresW-1:0] PresLast = PresW'(RUN_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [1:0]          run_sync_q, run_sync_d;
    logic [1:0]          step_sync_q, step_sync_d;
    logic [DebW-1:0]     deb_cnt_q, deb_cnt_d;
    logic                step_db_q, step_db_d;
    logic                step_db_dly_q;
    logic                step_evt_q, step_evt_d;
    logic [PresW-1:0]    presc_q, presc_d;
    logic                armed_q, armed_d;
    logic                cpu_en_q, cpu_en_d;
    logic [CNT_BITS-1:0] instr_count_q, instr_count_d;

    logic run_s, step_s, tick, hit;

    assign run_s  = run_sync_q[1];
    assign step_s = step_sync_q[1];
    assign tick   = (presc_q == PresLast);
    assign hit    = bus.bkpt_en & armed_q & (bus.pc == bus.bkpt_addr);

    // Input conditioning: synchronizers, debounce and step edge detect.
    always_comb begin
        run_sync_d  = {run_sync_q[0], bus.run_sw};
        step_sync_d = {step_sync_q[0], bus.step_btn};
        deb_cnt_d   = '0;
        step_db_d   = step_db_q;
        if (step_s != step_db_q) begin
            if (deb_cnt_q == DebLast) begin
                step_db_d = step_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        step_evt_d = step_db_q & ~step_db_dly_q;
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHalt;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalt: begin
                if (run_s) begin
                    state_d = StRun;
                end else if (step_evt_q) begin
                    state_d = StStep;
                end
            end
            StStep: state_d = StHalt;
            StRun: begin
                if (!run_s) begin
                    state_d = StHalt;
                end else if (tick && hit) begin
                    state_d = StBreak;
                end
            end
            StBreak: begin
                if (!run_s) begin
                    state_d = StHalt;
                end else if (step_evt_q) begin
                    state_d = StStep;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // cpu_en is registered so it is high exactly in the STEP cycle or the cycle after a tick.
    always_comb begin
        presc_d  = presc_q;
        armed_d  = armed_q;
        cpu_en_d = (state_d == StStep);
        unique case (state_q)
            StHalt: begin
                presc_d = '0;
                armed_d = 1'b0;
            end
            StRun: begin
                if (run_s) begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick && !hit) begin
                        cpu_en_d = 1'b1;
                        armed_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        instr_count_d = bus.clr_cnt ? '0 : instr_count_q + CNT_BITS'(cpu_en_q);
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_q    <= '0;
            step_sync_q   <= '0;
            deb_cnt_q     <= '0;
            step_db_q     <= 1'b0;
            step_db_dly_q <= 1'b0;
            step_evt_q    <= 1'b0;
            presc_q       <= '0;
            armed_q       <= 1'b0;
            cpu_en_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            run_sync_q    <= run_sync_d;
            step_sync_q   <= step_sync_d;
            deb_cnt_q     <= deb_cnt_d;
            step_db_q     <= step_db_d;
            step_db_dly_q <= step_db_q;
            step_evt_q    <= step_evt_d;
            presc_q       <= presc_d;
            armed_q       <= armed_d;
            cpu_en_q      <= cpu_en_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q != StRun);
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: a PC-incrementing CPU model plus a scoreboard of expected
// cpu_en pulses (PC and cycle), with direct checks of state and instruction count.
module tb_cpu_step_ctrl;

    localparam int unsigned RUN_DIV = 4;
    localparam int unsigned DEB     = 4;
    localparam int unsigned CB      = 8;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] cyc;
    } exp_t;

    logic clk_2 = 1'b0;
    logic rst_n;
    logic pc_clr;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    cpu_step_ctrl_if #(.NBITS_TOP(8), .CNT_BITS(CB)) bus ();

    cpu_step_ctrl #(
        .NBITS_TOP (8),
        .RUN_DIV   (RUN_DIV),
        .DEB_CYCLES(DEB),
        .CNT_BITS  (CB)
    ) dut (
        .clk_2(clk_2),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    // CPU model: each enable retires one instruction.
    always @(posedge clk_2) begin
        if (pc_clr) bus.pc <= 8'd0;
        else if (bus.cpu_en) bus.pc <= bus.pc + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk_2) begin
        if (rst_n && bus.cpu_en) begin
            check_eq("pulse_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_pc", 32'(bus.pc), 32'(mon_e.pc));
                check_eq("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic push_run(input int n, input logic [7:0] pc0, input int first);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.pc  = pc0 + 8'(k);
            e.cyc = 32'(first + k * RUN_DIV);
            exp_q.push_back(e);
        end
    endtask

    task automatic raise_run(input int n, input logic [7:0] pc0);
        @(posedge clk_2); #1;
        bus.run_sw = 1'b1;
        // 2 sync flops + HALT->RUN edge, then RUN_DIV cycles to the first pulse.
        push_run(n, pc0, cyc + 3 + RUN_DIV);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_2); #1;
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic pulse_sig_clr_cnt();
        @(posedge clk_2); #1; bus.clr_cnt = 1'b1;
        @(posedge clk_2); #1; bus.clr_cnt = 1'b0;
    endtask

    task automatic pulse_pc_clr();
        @(posedge clk_2); #1; pc_clr = 1'b1;
        @(posedge clk_2); #1; pc_clr = 1'b0;
    endtask

    task automatic step_press(input logic [7:0] pc_exp);
        exp_t e;
        @(posedge clk_2); #1;
        bus.step_btn = 1'b1;
        e.pc  = pc_exp;
        e.cyc = 32'(cyc + 2 + DEB + 2);
        exp_q.push_back(e);
        drain("step_pulse_seen", 40);
        check_eq("state_step", 32'(bus.state), 2);
    endtask

    task automatic step_release();
        bus.step_btn = 1'b0;
        wait_cyc(DEB + 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pc_clr = 1'b1;
        bus.run_sw = 1'b0;
        bus.step_btn = 1'b0;
        bus.bkpt_en = 1'b0;
        bus.bkpt_addr = 8'h05;
        bus.clr_cnt = 1'b0;
        #1;
        check_eq("rst_state", 32'(bus.state), 0);
        check_eq("rst_cpu_en", 32'(bus.cpu_en), 0);
        check_eq("rst_count", 32'(bus.instr_count), 0);
        repeat (3) @(negedge clk_2);
        rst_n = 1'b1;
        pc_clr = 1'b0;
        wait_cyc(5);
        check_eq("idle_state", 32'(bus.state), 0);
        check_eq("idle_halted", 32'(bus.halted), 1);

        // Bouncy step: 1/0/1 at one-cycle spacing, then held.
        @(posedge clk_2); #1; bus.step_btn = 1'b1;
        @(posedge clk_2); #1; bus.step_btn = 1'b0;
        step_press(8'h00);
        wait_cyc(1);
        check_eq("step_to_halt", 32'(bus.state), 0);
        check_eq("step_count", 32'(bus.instr_count), 1);
        step_release();
        check_eq("step_release_count", 32'(bus.instr_count), 1);

        // Free run, breakpoint disabled, PC runs through bkpt_addr.
        pulse_sig_clr_cnt();
        check_eq("clr_count", 32'(bus.instr_count), 0);
        pulse_pc_clr();
        raise_run(10, 8'h00);
        drain("freerun_drain", 60);
        bus.run_sw = 1'b0;
        wait_cyc(12);
        check_eq("freerun_count", 32'(bus.instr_count), 10);
        check_eq("freerun_halt", 32'(bus.state), 0);
        check_eq("freerun_pc", 32'(bus.pc), 10);

        // Breakpoint at 0x05.
        pulse_sig_clr_cnt();
        pulse_pc_clr();
        bus.bkpt_en = 1'b1;
        raise_run(5, 8'h00);
        drain("bkpt_drain", 40);
        wait_cyc(10);
        check_eq("bkpt_state", 32'(bus.state), 3);
        check_eq("bkpt_halted", 32'(bus.halted), 1);
        check_eq("bkpt_count", 32'(bus.instr_count), 5);
        check_eq("bkpt_pc", 32'(bus.pc), 5);

        // Step out of BREAK with run still high: STEP, HALT, then back to RUN.
        step_press(8'h05);
        bus.bkpt_addr = 8'h0c;
        push_run(6, 8'h06, cyc + 2 + RUN_DIV);
        wait_cyc(1);
        check_eq("resume_halt", 32'(bus.state), 0);
        wait_cyc(1);
        check_eq("resume_run", 32'(bus.state), 1);
        check_eq("resume_not_halted", 32'(bus.halted), 0);
        bus.step_btn = 1'b0;
        drain("resume_drain", 60);
        wait_cyc(10);
        check_eq("rebreak_state", 32'(bus.state), 3);
        check_eq("rebreak_pc", 32'(bus.pc), 12);
        check_eq("rebreak_count", 32'(bus.instr_count), 12);
        bus.run_sw = 1'b0;
        wait_cyc(6);
        check_eq("break_to_halt", 32'(bus.state), 0);

        // Breakpoint on the very first PC: entry with armed clear must not stop it.
        pulse_pc_clr();
        bus.bkpt_addr = 8'h00;
        raise_run(3, 8'h00);
        drain("armed_drain", 40);
        bus.run_sw = 1'b0;
        wait_cyc(8);
        check_eq("armed_pc", 32'(bus.pc), 3);
        check_eq("armed_count", 32'(bus.instr_count), 15);

        // Counter wrap at all-ones.
        bus.bkpt_en = 1'b0;
        pulse_sig_clr_cnt();
        raise_run(255, 8'h03);
        drain("wrap_drain", 255 * RUN_DIV + 40);
        bus.run_sw = 1'b0;
        wait_cyc(8);
        check_eq("count_all_ones", 32'(bus.instr_count), 32'hff);
        step_press(8'h02);
        wait_cyc(1);
        check_eq("count_wrap", 32'(bus.instr_count), 0);
        step_release();

        // Clear coinciding with a pulse wins.
        raise_run(2, 8'h03);
        drain("pre_clr_drain", 40);
        bus.run_sw = 1'b0;
        wait_cyc(8);
        check_eq("pre_clr_count", 32'(bus.instr_count), 2);
        raise_run(1, 8'h05);
        drain("clr_drain", 40);
        bus.clr_cnt = 1'b1;
        bus.run_sw = 1'b0;
        wait_cyc(1);
        bus.clr_cnt = 1'b0;
        check_eq("clr_vs_en", 32'(bus.instr_count), 0);
        wait_cyc(8);

        // Asynchronous reset in the middle of a RUN pulse cycle.
        raise_run(2, 8'h06);
        drain("prerst_drain", 40);
        rst_n = 1'b0;
        bus.run_sw = 1'b0;
        #1;
        check_eq("async_rst_cpu_en", 32'(bus.cpu_en), 0);
        check_eq("async_rst_count", 32'(bus.instr_count), 0);
        check_eq("async_rst_state", 32'(bus.state), 0);
        check_eq("async_rst_halted", 32'(bus.halted), 1);
        repeat (3) @(negedge clk_2);
        rst_n = 1'b1;
        wait_cyc(10);
        check_eq("post_rst_state", 32'(bus.state), 0);
        check_eq("post_rst_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
